// File: rtl/level_controller.sv
// Game-progress sequencer: counts hits and lives and owns the speed-mux level select.
// Level changes are applied only on a rising edge of the fed-back slow clock `tick`.
module level_controller #(
  parameter int P_LEVEL          = 2,
  parameter int ROUNDS_PER_LEVEL = 4,
  parameter int LIVES            = 3,
  parameter int CNT_W            = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               hit,
  input  logic               miss,
  input  logic               tick,
  output logic [P_LEVEL-1:0] level,
  output logic [CNT_W-1:0]   round_cnt,
  output logic [CNT_W-1:0]   lives_left,
  output logic               playing,
  output logic               won,
  output logic               game_over
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PLAY   = 3'd1;
  localparam logic [2:0] S_CHANGE = 3'd2;
  localparam logic [2:0] S_WON    = 3'd3;
  localparam logic [2:0] S_OVER   = 3'd4;

  localparam logic [CNT_W-1:0]   LAST_ROUND = CNT_W'(ROUNDS_PER_LEVEL - 1);
  localparam logic [CNT_W-1:0]   LIVES_INIT = CNT_W'(LIVES);
  localparam logic [P_LEVEL-1:0] TOP_LEVEL  = '1;

  logic [2:0] state;
  logic       tick_q;
  logic       tick_rise;

  assign tick_rise = tick & ~tick_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      level      <= '0;
      round_cnt  <= '0;
      lives_left <= LIVES_INIT;
      tick_q     <= 1'b0;
    end else begin
      tick_q <= tick;
      case (state)
        S_IDLE, S_WON, S_OVER: begin
          if (start) begin
            state      <= S_PLAY;
            level      <= '0;
            round_cnt  <= '0;
            lives_left <= LIVES_INIT;
          end
        end
        S_PLAY: begin
          // miss outranks hit when both arrive together
          if (miss) begin
            if (lives_left == CNT_W'(1)) begin
              state      <= S_OVER;
              lives_left <= '0;
            end else begin
              lives_left <= lives_left - CNT_W'(1);
            end
          end else if (hit) begin
            if (round_cnt == LAST_ROUND) begin
              round_cnt <= '0;
              state     <= (level == TOP_LEVEL) ? S_WON : S_CHANGE;
            end else begin
              round_cnt <= round_cnt + CNT_W'(1);
            end
          end
        end
        S_CHANGE: begin
          if (tick_rise) begin
            level <= level + P_LEVEL'(1);
            state <= S_PLAY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign playing   = (state == S_PLAY) || (state == S_CHANGE);
  assign won       = (state == S_WON);
  assign game_over = (state == S_OVER);

endmodule

// File: tb/tb_level_controller.sv
// Directed scoreboard bench for level_controller: expectations queued per step, checked after each edge.
module tb_level_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       start, hit, miss, tick;
  logic [1:0] level;
  logic [2:0] round_cnt, lives_left;
  logic       playing, won, game_over;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    string      tag;
    logic [1:0] level;
    logic [2:0] round_cnt;
    logic [2:0] lives_left;
    logic       playing;
    logic       won;
    logic       game_over;
  } exp_t;

  exp_t sb[$];

  level_controller #(
    .P_LEVEL(2),
    .ROUNDS_PER_LEVEL(4),
    .LIVES(3),
    .CNT_W(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .hit(hit),
    .miss(miss),
    .tick(tick),
    .level(level),
    .round_cnt(round_cnt),
    .lives_left(lives_left),
    .playing(playing),
    .won(won),
    .game_over(game_over)
  );

  always #5 clock = ~clock;

  task automatic expect_out(input string tag, input logic [1:0] l, input logic [2:0] rc,
                            input logic [2:0] lv, input logic pl, input logic wn, input logic go);
    exp_t e;
    e.tag = tag; e.level = l; e.round_cnt = rc; e.lives_left = lv;
    e.playing = pl; e.won = wn; e.game_over = go;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: got no expectation, required one");
    end else begin
      e = sb.pop_front();
      assert ({level, round_cnt, lives_left, playing, won, game_over} ===
              {e.level, e.round_cnt, e.lives_left, e.playing, e.won, e.game_over})
      else begin
        errors++;
        $error("FAIL %s: got lvl=%0d rc=%0d lives=%0d pl=%0b won=%0b go=%0b, required lvl=%0d rc=%0d lives=%0d pl=%0b won=%0b go=%0b",
               e.tag, level, round_cnt, lives_left, playing, won, game_over,
               e.level, e.round_cnt, e.lives_left, e.playing, e.won, e.game_over);
      end
    end
  endtask

  task automatic step(input logic s, input logic h, input logic m, input logic t,
                      input string tag, input logic [1:0] l, input logic [2:0] rc,
                      input logic [2:0] lv, input logic pl, input logic wn, input logic go);
    @(negedge clock);
    start = s; hit = h; miss = m; tick = t;
    expect_out(tag, l, rc, lv, pl, wn, go);
    @(posedge clock);
    #1;
    check_out();
    start = 1'b0; hit = 1'b0; miss = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hit = 1'b0; miss = 1'b0; tick = 1'b0;
    #7;
    expect_out("reset_state", 2'd0, 3'd0, 3'd3, 1'b0, 1'b0, 1'b0);
    check_out();
    @(negedge clock);
    reset = 1'b0;

    step(1'b0, 1'b1, 1'b1, 1'b0, "idle_ignores", 2'd0, 3'd0, 3'd3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, "start",        2'd0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, "hit1",         2'd0, 3'd1, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, "hit2",         2'd0, 3'd2, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, "hit3",         2'd0, 3'd3, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, "enter_change", 2'd0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, "chg_hit",      2'd0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, "chg_miss",     2'd0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, "chg_start",    2'd0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, "chg_tick",     2'd1, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, "post_tick",    2'd1, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0);

    // A rise coinciding with entry into CHANGE must not advance the level
    step(1'b0, 1'b1, 1'b0, 1'b0, "l1_hit1",       2'd1, 3'd1, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, "l1_hit2",       2'd1, 3'd2, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, "l1_hit3",       2'd1, 3'd3, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, "rise_on_entry", 2'd1, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, "tick_held",     2'd1, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, "tick_low",      2'd1, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, "tick_rise_l2",  2'd2, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, "l2_idle",       2'd2, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0);

    step(1'b0, 1'b1, 1'b0, 1'b0, "l2_hit1",      2'd2, 3'd1, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, "l2_hit2",      2'd2, 3'd2, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, "hit_and_miss", 2'd2, 3'd2, 3'd2, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, "l2_miss",      2'd2, 3'd2, 3'd1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, "l2_hit3",      2'd2, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, "l2_change",    2'd2, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset while in CHANGE, observed before any further clock edge
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    expect_out("async_reset", 2'd0, 3'd0, 3'd3, 1'b0, 1'b0, 1'b0);
    check_out();
    @(negedge clock);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b1, "change_lost", 2'd0, 3'd0, 3'd3, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, "stay_idle",   2'd0, 3'd0, 3'd3, 1'b0, 1'b0, 1'b0);

    step(1'b1, 1'b0, 1'b0, 1'b0, "start2",      2'd0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, "miss1",       2'd0, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, "miss2",       2'd0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, "miss3_over",  2'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, "over_hit",    2'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, "over_miss",   2'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, "start_w_hit", 2'd0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, "first_hit",   2'd0, 3'd1, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, "play_start",  2'd0, 3'd1, 3'd3, 1'b1, 1'b0, 1'b0);

    @(negedge clock);
    reset = 1'b1;
    tick = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, "start_win", 2'd0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0);
    for (int lv = 0; lv < 4; lv++) begin
      for (int r = 0; r < 4; r++) begin
        step(1'b0, 1'b1, 1'b0, 1'b0, "win_hit", 2'(lv), (r < 3) ? 3'(r + 1) : 3'd0, 3'd3,
             !(lv == 3 && r == 3), (lv == 3 && r == 3), 1'b0);
      end
      if (lv < 3) begin
        step(1'b0, 1'b0, 1'b0, 1'b1, "win_tick",     2'(lv + 1), 3'd0, 3'd3, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, "win_tick_low", 2'(lv + 1), 3'd0, 3'd3, 1'b1, 1'b0, 1'b0);
      end
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, "won_hold", 2'd3, 3'd0, 3'd3, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, "restart",  2'd0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_drain: got %0d leftover entries, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
